shreg_seq_ctrl: RTL
===================

Name: shreg_seq_ctrl

Overview:
- Command sequencer that drives the 4-bit universal shift register's control pins (ENB, DIR, MODO, D, S_IN) from a valid/ready command interface.
- Executes parallel-load, serial-shift, circular-rotate and load-then-rotate operations for a programmed number of steps.
- Returns the final register contents and the serial-out bit stream to the requester.
- Sits between a host/test controller and the shift register, replacing hand-timed stimulus sequences.

Parameters:
- WIDTH, 4, shift register width; sets the width of D/Q/CMD_DATA/RESULT.
- CNT_W, 4, step counter width; max steps = 2^CNT_W-1.
- LOG_W, 8, depth of the captured serial-out history.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  controller idle; command accepted on CMD_VALID&&CMD_READY at rising CLK.
- CMD_OP  in  2  00 serial shift (S_IN fed), 01 rotate, 10 parallel load, 11 load then rotate.
- CMD_DIR  in  1  1 = right, 0 = left.
- CMD_COUNT  in  CNT_W  number of shift/rotate steps.
- CMD_DATA  in  WIDTH  parallel load value.
- CMD_SIN  in  1  serial input bit, held for the whole op.
- REG_ENB  out  1  register enable (active high).
- REG_DIR  out  1  register direction.
- REG_MODO  out  2  register mode.
- REG_D  out  WIDTH  register parallel data.
- REG_SIN  out  1  register serial input.
- REG_Q  in  WIDTH  register parallel output.
- REG_SOUT  in  1  register serial output.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  WIDTH  REG_Q captured at completion.
- SOUT_LOG  out  LOG_W  serial-out bits shifted out during the last op, newest in bit 0.

Behaviour:
- Reset (async, RESET_L=0) values:
  - state IDLE, CMD_READY=1, REG_ENB=0, REG_DIR=0, REG_MODO=00, REG_D=0, REG_SIN=0.
  - DONE=0, RESULT=0, SOUT_LOG=0, counter=0, latched command cleared.
- Reset mid-operation aborts the op immediately: REG_ENB drops asynchronously and no DONE is issued.
- FSM states: IDLE, LOAD, SHIFT, SETTLE.
- IDLE: CMD_READY=1, REG_ENB=0.
  - On accept: latch OP/DIR/COUNT/DATA/SIN and clear SOUT_LOG.
  - Next state: LOAD for op 10/11; SHIFT for op 00/01 with COUNT>0; SETTLE for op 00/01 with COUNT=0.
- LOAD (1 cycle): REG_ENB=1, REG_MODO=10, REG_D=latched data.
  - Next state: SHIFT if op 11 and COUNT>0, else SETTLE.
- SHIFT (COUNT cycles): REG_ENB=1, REG_MODO=00 (op 00) or 01 (op 01/11), REG_DIR=latched DIR, REG_SIN=latched SIN.
  - Each edge: counter decrements; SOUT_LOG <= {SOUT_LOG[LOG_W-2:0], REG_SOUT}.
  - Counter reaching 1 -> SETTLE.
- SETTLE (1 cycle): REG_ENB=0. At its closing edge: RESULT <= REG_Q, DONE <= 1, state -> IDLE.
- DONE is high exactly one cycle, coincident with CMD_READY re-asserting. RESULT holds until the next completion.
- Latency (cycle 1 = cycle after the accept edge), DONE visible in cycle:
  - op 10: 3
  - op 00/01 with N steps: N+2 (COUNT=0: 2)
  - op 11: N+3
- REG_* outputs are registered, changing only on CLK edges (reset excepted).
- REG_D and REG_SIN hold their last values in IDLE.
- Command inputs are ignored while CMD_READY=0; a CMD_VALID held through busy is accepted at the first IDLE edge.
- A back-to-back command may be accepted in the same cycle DONE is high.
- More than LOG_W steps: SOUT_LOG keeps only the newest LOG_W bits.

Decomposition:
- Shared package/defines file holds:
  - mode constants MODO_00/01/10, ENABLE, HIGH/LOW, DIR_RIGHT/DIR_LEFT;
  - op encodings OP_SHIFT/OP_ROT/OP_LOAD/OP_LOAD_ROT;
  - state encodings ST_IDLE/ST_LOAD/ST_SHIFT/ST_SETTLE.
- Optional sub-module shreg_step_counter: down-counter with load/dec/last flag.
- The shift register itself stays external and is instantiated alongside in the bench.

Test Plan:
- Reset mid-SHIFT (op 01, COUNT=5, RESET_L low in cycle 3) -> REG_ENB=0 immediately; no DONE; after release CMD_READY=1 and RESULT=0000.
- Op 10, DATA=1010 -> REG_MODO=10, REG_ENB=1 in cycle 1 only; DONE in cycle 3; RESULT=1010.
- Op 11, DATA=0001, DIR=1, COUNT=1 -> LOAD then one rotate step; DONE in cycle 4; RESULT=1000. Same with COUNT=4 -> RESULT=0001, DONE in cycle 7.
- Op 00, register preloaded with 1111, DIR=1, SIN=0, COUNT=4 -> RESULT=0000; SOUT_LOG[3:0]=1111; REG_ENB high exactly 4 cycles.
- Op 01, COUNT=0 -> no REG_ENB pulse; DONE in cycle 2; RESULT equals the pre-op Q.
- CMD_VALID held high with two queued commands (load 0110, then rotate left COUNT=1) -> second accepted on the DONE cycle of the first; final RESULT=1100.

Source files
------------

// File: rtl/shreg_seq_ctrl_pkg.sv
// shreg_seq_ctrl_pkg: shared control encodings for the shift-register sequencer
package shreg_seq_ctrl_pkg;
    localparam logic [1:0] MODO_00   = 2'b00;
    localparam logic [1:0] MODO_01   = 2'b01;
    localparam logic [1:0] MODO_10   = 2'b10;
    localparam logic       ENABLE    = 1'b1;
    localparam logic       HIGH      = 1'b1;
    localparam logic       LOW       = 1'b0;
    localparam logic       DIR_RIGHT = 1'b1;
    localparam logic       DIR_LEFT  = 1'b0;

    localparam logic [1:0] OP_SHIFT    = 2'b00;
    localparam logic [1:0] OP_ROT      = 2'b01;
    localparam logic [1:0] OP_LOAD     = 2'b10;
    localparam logic [1:0] OP_LOAD_ROT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;
endpackage

// File: rtl/shreg_seq_ctrl_step_counter.sv
// shreg_step_counter: loadable down-counter with last-step and zero flags
module shreg_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // load has priority so a new command always restarts the count
    always_comb begin
        cnt_d = load ? load_val : (dec ? cnt_q - 1'b1 : cnt_q);
    end

    // count register
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/shreg_seq_ctrl.sv
// shreg_seq_ctrl: valid/ready command sequencer driving a 4-bit universal shift register
module shreg_seq_ctrl
    import shreg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int LOG_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_DIR,
    input  logic [CNT_W-1:0] CMD_COUNT,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic             CMD_SIN,
    output logic             REG_ENB,
    output logic             REG_DIR,
    output logic [1:0]       REG_MODO,
    output logic [WIDTH-1:0] REG_D,
    output logic             REG_SIN,
    input  logic [WIDTH-1:0] REG_Q,
    input  logic             REG_SOUT,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [LOG_W-1:0] SOUT_LOG
);
    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             dir_q, dir_d, sin_q, sin_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ready_q, ready_d, enb_q, enb_d, rdir_q, rdir_d, rsin_q, rsin_d;
    logic [1:0]       modo_q, modo_d;
    logic [WIDTH-1:0] rd_q, rd_d, result_q, result_d;
    logic             done_q, done_d;
    logic [LOG_W-1:0] log_q, log_d;
    logic             accept, cnt_last, cnt_zero;

    assign accept = CMD_VALID && ready_q;

    shreg_step_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .load     (accept),
        .dec      (state_q == ST_SHIFT),
        .load_val (CMD_COUNT),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    // next state and command latch; register pins are derived from the next state so they
    // line up with the state they belong to instead of lagging it by a cycle
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dir_d    = dir_q;
        sin_d    = sin_q;
        data_d   = data_q;
        log_d    = log_q;
        result_d = result_q;
        done_d   = LOW;
        case (state_q)
            ST_IDLE: if (CMD_VALID) begin
                op_d    = CMD_OP;
                dir_d   = CMD_DIR;
                sin_d   = CMD_SIN;
                data_d  = CMD_DATA;
                log_d   = '0;
                state_d = CMD_OP[1] ? ST_LOAD : (CMD_COUNT != '0 ? ST_SHIFT : ST_SETTLE);
            end
            ST_LOAD:  state_d = (op_q == OP_LOAD_ROT && !cnt_zero) ? ST_SHIFT : ST_SETTLE;
            ST_SHIFT: begin
                log_d   = {log_q[LOG_W-2:0], REG_SOUT};
                state_d = cnt_last ? ST_SETTLE : ST_SHIFT;
            end
            default: begin
                result_d = REG_Q;
                done_d   = HIGH;
                state_d  = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        enb_d   = (state_d == ST_LOAD || state_d == ST_SHIFT) ? ENABLE : ~ENABLE;
        modo_d  = (state_d == ST_LOAD) ? MODO_10 :
                  (state_d == ST_SHIFT) ? (op_d == OP_SHIFT ? MODO_00 : MODO_01) : MODO_00;
        rdir_d  = (state_d == ST_SHIFT) ? dir_d : rdir_q;
        rsin_d  = (state_d == ST_SHIFT) ? sin_d : rsin_q;
        rd_d    = (state_d == ST_LOAD) ? data_d : rd_q;
    end

    // single state/output register bank; async reset aborts any op without a DONE
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SHIFT;
            dir_q    <= DIR_LEFT;
            sin_q    <= LOW;
            data_q   <= '0;
            ready_q  <= HIGH;
            enb_q    <= ~ENABLE;
            rdir_q   <= DIR_LEFT;
            rsin_q   <= LOW;
            modo_q   <= MODO_00;
            rd_q     <= '0;
            result_q <= '0;
            done_q   <= LOW;
            log_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dir_q    <= dir_d;
            sin_q    <= sin_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            enb_q    <= enb_d;
            rdir_q   <= rdir_d;
            rsin_q   <= rsin_d;
            modo_q   <= modo_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            done_q   <= done_d;
            log_q    <= log_d;
        end
    end

    assign CMD_READY = ready_q;
    assign REG_ENB   = enb_q;
    assign REG_DIR   = rdir_q;
    assign REG_MODO  = modo_q;
    assign REG_D     = rd_q;
    assign REG_SIN   = rsin_q;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign SOUT_LOG  = log_q;
endmodule
